// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST engine.
// Holds the FSM state encoding and reference truth tables for 2-input cells.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  // Bit i is the expected output for input vector i.
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/bist_vector_counter.sv
// Vector index and settle-time counter for the gate BIST engine.
// sample_now marks the final settle cycle, so the next cycle is the sample cycle.
module bist_vector_counter #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            advance,
  output logic [N_IN-1:0] idx,
  output logic            last_vec,
  output logic            sample_now
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  logic [N_IN-1:0] idx_reg;
  logic [3:0]      cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      idx_reg <= '0;
      cnt_reg <= SETTLE_L;
    end else if (advance) begin
      idx_reg <= idx_reg + 1'b1;
      cnt_reg <= SETTLE_L;
    end else if (cnt_reg != 4'd0) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  assign idx        = idx_reg;
  assign last_vec   = &idx_reg;
  assign sample_now = (cnt_reg == 4'd1);

endmodule

// File: rtl/gate_bist_checker.sv
// Exhaustive BIST for an N_IN-input combinational gate against a truth table.
// Drives each vector, waits SETTLE cycles, samples resp and records mismatches.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int                     N_IN   = 2,
  parameter int                     SETTLE = 2,
  parameter logic [(2**N_IN)-1:0]   EXP_TT = 4'b1110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  bist_state_e     state_reg, state_next;
  logic            load, advance, last_vec, sample_now, mismatch;
  logic [N_IN-1:0] idx;
  logic [N_IN:0]   err_count_reg;
  logic [N_IN-1:0] first_fail_vec_reg;
  logic            first_fail_valid_reg;

  bist_vector_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .advance    (advance),
    .idx        (idx),
    .last_vec   (last_vec),
    .sample_now (sample_now)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // With SETTLE=0 the WAIT state is skipped and every cycle is a sample.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (SETTLE == 0) ? SAMPLE : WAIT;
        end
      end
      WAIT: begin
        if (sample_now) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (last_vec) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = (SETTLE == 0) ? SAMPLE : WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mismatch = (state_reg == SAMPLE) && (resp != EXP_TT[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg        <= '0;
      first_fail_vec_reg   <= '0;
      first_fail_valid_reg <= 1'b0;
    end else if (load) begin
      err_count_reg        <= '0;
      first_fail_vec_reg   <= '0;
      first_fail_valid_reg <= 1'b0;
    end else if (mismatch) begin
      err_count_reg <= err_count_reg + {{N_IN{1'b0}}, 1'b1};
      if (!first_fail_valid_reg) begin
        first_fail_vec_reg   <= idx;
        first_fail_valid_reg <= 1'b1;
      end
    end
  end

  assign stim             = idx;
  assign busy             = (state_reg == WAIT) || (state_reg == SAMPLE);
  assign done             = (state_reg == DONE);
  assign pass             = done && (err_count_reg == '0);
  assign err_count        = err_count_reg;
  assign first_fail_vec   = first_fail_vec_reg;
  assign first_fail_valid = first_fail_valid_reg;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: OR/AND/stuck-at models, restarts, reset abort, SETTLE=0.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] stim_a, stim_b, ffv_a, ffv_b;
  logic       resp_a, resp_b;
  logic       busy_a, done_a, pass_a, ffvalid_a;
  logic       busy_b, done_b, pass_b, ffvalid_b;
  logic [2:0] err_a, err_b;
  int         mode_a = 0;  // 0: OR, 1: stuck-at-0, 2: AND
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode_a)
      1:       resp_a = 1'b0;
      2:       resp_a = stim_a[0] & stim_a[1];
      default: resp_a = stim_a[0] | stim_a[1];
    endcase
  end
  assign resp_b = stim_b[0] | stim_b[1];

  gate_bist_checker #(.N_IN(2), .SETTLE(2), .EXP_TT(TT_OR)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffvalid_a)
  );

  gate_bist_checker #(.N_IN(2), .SETTLE(0), .EXP_TT(TT_OR)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffvalid_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start at a negedge, then check each of the 12 busy cycles and the done cycle.
  task automatic run_a(input int repulse_at, input logic [2:0] exp_err,
                       input logic [1:0] exp_ffv, input logic exp_ffvalid);
    start_a = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 12; n++) begin
      if (n == 0) begin
        check("a_clear_err", err_a, 0);
        check("a_clear_ffvalid", ffvalid_a, 0);
      end
      check("a_busy", busy_a, 1);
      check("a_done_low", done_a, 0);
      check("a_stim", stim_a, n / 3);
      start_a = (n == repulse_at);
      @(negedge clk);
    end
    start_a = 1'b0;
    check("a_done", done_a, 1);
    check("a_busy_end", busy_a, 0);
    check("a_stim_last", stim_a, 3);
    check("a_err", err_a, exp_err);
    check("a_ffvalid", ffvalid_a, exp_ffvalid);
    if (exp_ffvalid) check("a_ffv", ffv_a, exp_ffv);
    check("a_pass", pass_a, exp_err == 0);
    $display("run_a: err=%0d ffv=%0d ffvalid=%0d pass=%0d", err_a, ffv_a, ffvalid_a, pass_a);
  endtask

  initial begin
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_stim", stim_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mode_a = 0; run_a(-1, 3'd0, 2'd0, 1'b0);   // correct OR
    mode_a = 1; run_a(-1, 3'd3, 2'd1, 1'b1);   // stuck-at-0, restarted from DONE
    mode_a = 2; run_a(-1, 3'd2, 2'd1, 1'b1);   // AND cell against OR table
    mode_a = 0; run_a(5, 3'd0, 2'd0, 1'b0);    // start re-pulsed mid-run is ignored

    // Abort a failing run at cycle 7 with reset.
    mode_a = 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_err_before_rst", err_a, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_err", err_a, 0);
    check("abort_ffvalid", ffvalid_a, 0);
    check("abort_ffv", ffv_a, 0);
    check("abort_stim", stim_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy_a, 0);
    check("idle_done", done_a, 0);
    mode_a = 0; run_a(-1, 3'd0, 2'd0, 1'b0);

    // SETTLE=0: one vector per cycle, done four cycles after start.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check("b_busy", busy_b, 1);
      check("b_stim", stim_b, n);
      check("b_done_low", done_b, 0);
      @(negedge clk);
    end
    check("b_done", done_b, 1);
    check("b_pass", pass_b, 1);
    check("b_err", err_b, 0);
    check("b_ffvalid", ffvalid_b, 0);
    check("b_ffv", ffv_b, 0);
    $display("run_b: err=%0d pass=%0d", err_b, pass_b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
